// File: rtl/bootrom_wb_arbiter.sv
// rtl/bootrom_wb_arbiter.sv - two-master Wishbone classic arbiter for the boot ROM slave
//
// Purpose: round-robin arbitration between the core fetch port (master 0) and
// the debug/loader port (master 1) onto a single boot ROM Wishbone slave. The
// grant is held for the whole cycle (cyc high). A watchdog aborts cycles that
// the slave never acknowledges and reports err to the owning master.
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_mN_wb_*                 master N request (adr/dat/sel/we/cyc/stb), N = 0,1
//   o_mN_wb_rdt/ack/err       master N response
//   o_s_wb_*                  request forwarded to the boot ROM slave
//   i_s_wb_rdt/ack            slave response
//   o_grant                   one-hot current owner, 00 when idle or aborting
module bootrom_wb_arbiter #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_m0_wb_adr,
    input  logic [31:0]   i_m0_wb_dat,
    input  logic [3:0]    i_m0_wb_sel,
    input  logic          i_m0_wb_we,
    input  logic          i_m0_wb_cyc,
    input  logic          i_m0_wb_stb,
    output logic [31:0]   o_m0_wb_rdt,
    output logic          o_m0_wb_ack,
    output logic          o_m0_wb_err,
    input  logic [AW-1:0] i_m1_wb_adr,
    input  logic [31:0]   i_m1_wb_dat,
    input  logic [3:0]    i_m1_wb_sel,
    input  logic          i_m1_wb_we,
    input  logic          i_m1_wb_cyc,
    input  logic          i_m1_wb_stb,
    output logic [31:0]   o_m1_wb_rdt,
    output logic          o_m1_wb_ack,
    output logic          o_m1_wb_err,
    output logic [AW-1:0] o_s_wb_adr,
    output logic [31:0]   o_s_wb_dat,
    output logic [3:0]    o_s_wb_sel,
    output logic          o_s_wb_we,
    output logic          o_s_wb_cyc,
    output logic          o_s_wb_stb,
    input  logic [31:0]   i_s_wb_rdt,
    input  logic          i_s_wb_ack,
    output logic [1:0]    o_grant
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

    state_t        state;
    logic          ptr;      // master that wins the next simultaneous request
    logic          owner;    // master granted most recently; still meaningful in ABORT
    logic [TW-1:0] count;
    logic          own_cyc;
    logic          timeout;

    // Owner's cyc, valid in GNTx and ABORT so an aborted cycle can be released.
    assign own_cyc = owner ? i_m1_wb_cyc : i_m0_wb_cyc;

    // Fires only while a strobe is actually presented to the slave; a
    // coincident ack takes precedence over the abort.
    assign timeout = ((state == GNT0 && i_m0_wb_stb) || (state == GNT1 && i_m1_wb_stb))
                     && !i_s_wb_ack && (count == LIMIT);

    always_comb begin
        o_s_wb_adr  = '0;
        o_s_wb_dat  = '0;
        o_s_wb_sel  = '0;
        o_s_wb_we   = 1'b0;
        o_s_wb_cyc  = 1'b0;
        o_s_wb_stb  = 1'b0;
        o_m0_wb_rdt = '0;
        o_m0_wb_ack = 1'b0;
        o_m1_wb_rdt = '0;
        o_m1_wb_ack = 1'b0;
        o_grant     = 2'b00;
        case (state)
            GNT0: begin
                o_s_wb_adr  = i_m0_wb_adr;
                o_s_wb_dat  = i_m0_wb_dat;
                o_s_wb_sel  = i_m0_wb_sel;
                o_s_wb_we   = i_m0_wb_we;
                o_s_wb_cyc  = i_m0_wb_cyc;
                o_s_wb_stb  = i_m0_wb_stb;
                o_m0_wb_rdt = i_s_wb_rdt;
                o_m0_wb_ack = i_s_wb_ack;
                o_grant     = 2'b01;
            end
            GNT1: begin
                o_s_wb_adr  = i_m1_wb_adr;
                o_s_wb_dat  = i_m1_wb_dat;
                o_s_wb_sel  = i_m1_wb_sel;
                o_s_wb_we   = i_m1_wb_we;
                o_s_wb_cyc  = i_m1_wb_cyc;
                o_s_wb_stb  = i_m1_wb_stb;
                o_m1_wb_rdt = i_s_wb_rdt;
                o_m1_wb_ack = i_s_wb_ack;
                o_grant     = 2'b10;
            end
            default: ;  // IDLE and ABORT: bus parked, late acks dropped
        endcase
    end

    assign o_m0_wb_err = timeout && (state == GNT0);
    assign o_m1_wb_err = timeout && (state == GNT1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            owner <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (i_m0_wb_cyc && (!i_m1_wb_cyc || !ptr)) begin
                        state <= GNT0;
                        owner <= 1'b0;
                    end else if (i_m1_wb_cyc) begin
                        state <= GNT1;
                        owner <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (!own_cyc) begin
                        state <= IDLE;
                        ptr   <= ~owner;
                        count <= '0;
                    end else if (timeout) begin
                        state <= ABORT;
                        count <= '0;
                    end else if (i_s_wb_ack) begin
                        count <= '0;
                    end else if (o_s_wb_stb) begin
                        count <= count + 1'b1;
                    end
                end
                default: begin  // ABORT
                    if (!own_cyc) begin
                        state <= IDLE;
                        ptr   <= ~owner;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bootrom_wb_arbiter.sv
// tb/tb_bootrom_wb_arbiter.sv - directed self-checking bench for bootrom_wb_arbiter
module tb_bootrom_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_adr = '0, m0_dat = '0, m1_adr = '0, m1_dat = '0;
    logic [3:0]  m0_sel = '0, m1_sel = '0;
    logic        m0_we = 1'b0, m0_cyc = 1'b0, m0_stb = 1'b0;
    logic        m1_we = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
    logic [31:0] m0_rdt, m1_rdt, s_dat, s_rdt = '0;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] s_adr;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc, s_stb, s_ack = 1'b0;
    logic [1:0]  grant;

    int total = 0;
    int fails = 0;

    bootrom_wb_arbiter #(.AW(32), .TIMEOUT(8), .TW(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_wb_adr(m0_adr), .i_m0_wb_dat(m0_dat), .i_m0_wb_sel(m0_sel),
        .i_m0_wb_we(m0_we), .i_m0_wb_cyc(m0_cyc), .i_m0_wb_stb(m0_stb),
        .o_m0_wb_rdt(m0_rdt), .o_m0_wb_ack(m0_ack), .o_m0_wb_err(m0_err),
        .i_m1_wb_adr(m1_adr), .i_m1_wb_dat(m1_dat), .i_m1_wb_sel(m1_sel),
        .i_m1_wb_we(m1_we), .i_m1_wb_cyc(m1_cyc), .i_m1_wb_stb(m1_stb),
        .o_m1_wb_rdt(m1_rdt), .o_m1_wb_ack(m1_ack), .o_m1_wb_err(m1_err),
        .o_s_wb_adr(s_adr), .o_s_wb_dat(s_dat), .o_s_wb_sel(s_sel),
        .o_s_wb_we(s_we), .o_s_wb_cyc(s_cyc), .o_s_wb_stb(s_stb),
        .i_s_wb_rdt(s_rdt), .i_s_wb_ack(s_ack),
        .o_grant(grant)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change 2 time units after the edge and
    // outputs are sampled 1 unit later, far from the next edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic v);
        m0_cyc = v;
        m0_stb = v;
    endtask

    task automatic set_m1(input logic v);
        m1_cyc = v;
        m1_stb = v;
    endtask

    initial begin
        // 1: reset held with m0 requesting
        set_m0(1'b1);
        repeat (3) step();
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_cyc", s_cyc, 1'b0);
        chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
        rst = 1'b0;
        #1;
        chk("rst_rel_grant_pre", grant, 2'b00);
        step();
        #1;
        chk("rst_rel_grant", grant, 2'b01);

        // 2: single read by m0
        m0_adr = 32'h0000_0010;
        #1;
        chk("rd_s_adr", s_adr, 32'h0000_0010);
        chk("rd_s_stb", s_stb, 1'b1);
        step();
        s_ack = 1'b1;
        s_rdt = 32'hDEAD_BEEF;
        #1;
        chk("rd_m0_ack", m0_ack, 1'b1);
        chk("rd_m0_rdt", m0_rdt, 32'hDEAD_BEEF);
        chk("rd_m1_ack", m1_ack, 1'b0);
        chk("rd_m1_rdt", m1_rdt, 32'h0);
        chk("rd_m0_err", m0_err, 1'b0);
        step();
        s_ack = 1'b0;
        set_m0(1'b0);
        #1;
        chk("rd_hold_grant", grant, 2'b01);
        step();
        #1;
        chk("rd_idle_grant", grant, 2'b00);

        // 3: contention, pointer back at master 0 after an async reset pulse
        rst = 1'b1;
        #1;
        rst = 1'b0;
        set_m0(1'b1);
        set_m1(1'b1);
        for (int r = 0; r < 6; r++) begin
            logic [1:0] exp_g;
            exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
            step();
            #1;
            chk($sformatf("cont_grant_%0d", r), grant, exp_g);
            s_ack = 1'b1;
            s_rdt = 32'h100 + r;
            #1;
            chk($sformatf("cont_acks_%0d", r), {m1_ack, m0_ack}, exp_g);
            step();
            s_ack = 1'b0;
            if (r % 2 == 0) set_m0(1'b0); else set_m1(1'b0);
            step();
            #1;
            chk($sformatf("cont_idle_%0d", r), grant, 2'b00);
            if (r % 2 == 0) set_m0(1'b1); else set_m1(1'b1);
        end
        set_m0(1'b0);
        set_m1(1'b0);
        step();
        step();

        // 4: m1 burst while m0 waits (pointer now at master 0)
        set_m1(1'b1);
        step();
        #1;
        chk("burst_grant1", grant, 2'b10);
        set_m0(1'b1);
        for (int k = 0; k < 4; k++) begin
            s_ack = 1'b1;
            s_rdt = 32'hA0 + k;
            #1;
            chk($sformatf("burst_m1_ack_%0d", k), m1_ack, 1'b1);
            chk($sformatf("burst_m1_rdt_%0d", k), m1_rdt, 32'hA0 + k);
            chk($sformatf("burst_m0_ack_%0d", k), {m0_ack, m0_err, m1_err}, 3'b000);
            chk($sformatf("burst_grant_%0d", k), grant, 2'b10);
            step();
        end
        s_ack = 1'b0;
        #1;
        chk("burst_still_m1", grant, 2'b10);
        set_m1(1'b0);
        step();
        #1;
        chk("burst_idle", grant, 2'b00);
        step();
        #1;
        chk("burst_m0_after", grant, 2'b01);
        set_m0(1'b0);
        step();
        step();

        // 5: watchdog timeout with TIMEOUT=8
        set_m0(1'b1);
        step();
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk($sformatf("to_err_%0d", k), m0_err, (k == 8) ? 1'b1 : 1'b0);
            chk($sformatf("to_stb_%0d", k), s_stb, 1'b1);
            step();
        end
        #1;
        chk("to_abort_grant", grant, 2'b00);
        chk("to_abort_stb", {s_cyc, s_stb}, 2'b00);
        chk("to_abort_err", m0_err, 1'b0);
        step();
        step();
        #1;
        chk("to_abort_held", grant, 2'b00);
        s_ack = 1'b1;
        s_rdt = 32'h5555_AAAA;
        #1;
        chk("late_ack", {m0_ack, m1_ack}, 2'b00);
        chk("late_rdt", m0_rdt, 32'h0);
        s_ack = 1'b0;
        set_m0(1'b0);
        step();
        #1;
        chk("to_idle", grant, 2'b00);
        step();

        // 6: ack on the 8th strobe clock wins over the timeout
        set_m0(1'b1);
        step();
        for (int k = 1; k <= 7; k++) begin
            #1;
            chk($sformatf("edge_err_%0d", k), m0_err, 1'b0);
            step();
        end
        s_ack = 1'b1;
        s_rdt = 32'h1234_5678;
        #1;
        chk("edge_ack", m0_ack, 1'b1);
        chk("edge_err8", m0_err, 1'b0);
        step();
        s_ack = 1'b0;
        #1;
        chk("edge_no_abort", grant, 2'b01);

        // asynchronous reset mid-cycle clears outputs without a clock edge
        rst = 1'b1;
        #1;
        chk("async_rst_grant", grant, 2'b00);
        chk("async_rst_cyc", s_cyc, 1'b0);
        rst = 1'b0;
        set_m0(1'b0);
        step();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
